// File: rtl/affine_addr_if.sv
// Handshake and configuration bundle for the N-dimensional affine address generator.
// master = the generator side, slave = the host/consumer side.
interface affine_addr_if #(
    parameter int DIMS  = 3,
    parameter int WIDTH = 16
);
    logic                    start;
    logic [DIMS*WIDTH-1:0]   cfg_extent;
    logic [DIMS*WIDTH-1:0]   cfg_delta;
    logic [WIDTH-1:0]        cfg_offset;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_addr;
    logic                    out_last;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, cfg_extent, cfg_delta, cfg_offset, out_ready,
        output out_valid, out_addr, out_last, busy, done
    );

    modport slave (
        output start, cfg_extent, cfg_delta, cfg_offset, out_ready,
        input  out_valid, out_addr, out_last, busy, done
    );
endinterface

// File: rtl/affine_addr_gen_nd.sv
// N-dimensional affine address generator: one nested loop per start, one address
// per accepted beat, delta[k] applied on each carry into dimension k.
module affine_addr_gen_nd #(
    parameter int DIMS  = 3,
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    affine_addr_if.master bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ext_q [DIMS];
    logic [WIDTH-1:0]   dlt_q [DIMS];
    logic [WIDTH-1:0]   idx_q [DIMS];
    logic [WIDTH-1:0]   idx_nxt [DIMS];
    logic [WIDTH-1:0]   ofs_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   step;
    logic               done_q;
    logic               any_zero;
    logic               all_max;
    logic               carried;
    logic               fire;
    logic               launch;

    always_comb begin
        any_zero = 1'b0;
        for (int d = 0; d < DIMS; d++) begin
            if (bus.cfg_extent[d*WIDTH +: WIDTH] == '0)
                any_zero = 1'b1;
        end
    end

    // Carry chain: the lowest dimension not yet at its max absorbs the step;
    // everything below it rewinds to zero.
    always_comb begin
        all_max = 1'b1;
        carried = 1'b0;
        step    = '0;
        for (int d = 0; d < DIMS; d++) begin
            idx_nxt[d] = idx_q[d];
            if (idx_q[d] != ext_q[d] - WIDTH'(1))
                all_max = 1'b0;
            if (!carried) begin
                if (idx_q[d] == ext_q[d] - WIDTH'(1)) begin
                    idx_nxt[d] = '0;
                end else begin
                    idx_nxt[d] = idx_q[d] + WIDTH'(1);
                    step       = dlt_q[d];
                    carried    = 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = (state_q == RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_last  = (state_q == RUN) && all_max;
    assign bus.out_addr  = acc_q + ofs_q;
    assign bus.done      = done_q;

    assign fire   = bus.out_valid && bus.out_ready;
    assign launch = (state_q == IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start && !any_zero) state_d = RUN;
            RUN:  if (fire && all_max)        state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < DIMS; d++) begin
                ext_q[d] <= '0;
                dlt_q[d] <= '0;
                idx_q[d] <= '0;
            end
            ofs_q  <= '0;
            acc_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (launch) begin
                for (int d = 0; d < DIMS; d++) begin
                    ext_q[d] <= bus.cfg_extent[d*WIDTH +: WIDTH];
                    dlt_q[d] <= bus.cfg_delta[d*WIDTH +: WIDTH];
                    idx_q[d] <= '0;
                end
                ofs_q  <= bus.cfg_offset;
                acc_q  <= '0;
                done_q <= any_zero;
            end else if (fire) begin
                // Final beat leaves acc/idx untouched; the next launch clears them.
                if (all_max) begin
                    done_q <= 1'b1;
                end else begin
                    for (int d = 0; d < DIMS; d++)
                        idx_q[d] <= idx_nxt[d];
                    acc_q <= acc_q + step;
                end
            end
        end
    end
endmodule

// File: tb/tb_affine_addr_gen_nd.sv
// Randomized bench for affine_addr_gen_nd against a closed-form beat-number model.
module tb_affine_addr_gen_nd;
    localparam int DIMS  = 3;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    affine_addr_if #(.DIMS(DIMS), .WIDTH(WIDTH)) bus ();

    affine_addr_gen_nd #(.DIMS(DIMS), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Beat b has seen (b/P[k] - b/P[k+1]) carries into dim k, where P[k] is the
    // product of the extents below k; the address is the offset plus those deltas.
    task automatic build(input logic [47:0] e, input logic [47:0] d, input logic [15:0] o,
                         output int total);
        int p [DIMS+1];
        int a;
        exp_q.delete();
        p[0] = 1;
        for (int k = 0; k < DIMS; k++) p[k+1] = p[k] * int'(e[k*16 +: 16]);
        total = p[DIMS];
        for (int b = 0; b < total; b++) begin
            a = int'(o);
            for (int k = 0; k < DIMS; k++)
                a += int'(d[k*16 +: 16]) * (b / p[k] - b / p[k+1]);
            exp_q.push_back(a[15:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the DUT idle (or showing done). Returns at the
    // sample where done is expected high, so a following call is back-to-back.
    // rmode: 0 ready held high, 1 pattern 1,0,0, 2 random.
    task automatic run(input logic [47:0] e, input logic [47:0] d, input logic [15:0] o,
                       input int rmode, input bit poke, input string nm);
        int total, beats, cyc;
        logic r;
        build(e, d, o, total);
        bus.cfg_extent = e;
        bus.cfg_delta  = d;
        bus.cfg_offset = o;
        bus.start      = 1'b1;
        bus.out_ready  = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.cfg_extent = {$urandom, $urandom};
        bus.cfg_delta  = {$urandom, $urandom};
        bus.cfg_offset = 16'($urandom);
        if (total == 0) begin
            check({nm, ".zero_valid"}, bus.out_valid, 0);
            check({nm, ".zero_busy"}, bus.busy, 0);
            check({nm, ".zero_done"}, bus.done, 1);
            return;
        end
        check({nm, ".first_done"}, bus.done, 0);
        beats = 0;
        cyc   = 0;
        while (beats < total && cyc < 2000) begin
            check({nm, ".valid"}, bus.out_valid, 1);
            check({nm, ".busy"}, bus.busy, 1);
            check({nm, ".addr"}, bus.out_addr, exp_q[beats]);
            check({nm, ".last"}, bus.out_last, (beats == total - 1));
            check({nm, ".done_mid"}, bus.done, 0);
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = r;
            bus.start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            bus.start = 1'b0;
            if (r) beats++;
            cyc++;
        end
        if (beats < total) check({nm, ".timeout"}, 0, 1);
        if (rmode == 0) check({nm, ".cycles"}, cyc, total);
        check({nm, ".end_valid"}, bus.out_valid, 0);
        check({nm, ".end_busy"}, bus.busy, 0);
        check({nm, ".end_done"}, bus.done, 1);
    endtask

    task automatic idle_check(input string nm);
        bus.start = 1'b0;
        tick();
        check({nm, ".idle_done"}, bus.done, 0);
        check({nm, ".idle_valid"}, bus.out_valid, 0);
    endtask

    initial begin
        logic [47:0] e, d;
        int total;
        bus.start      = 1'b0;
        bus.cfg_extent = '0;
        bus.cfg_delta  = '0;
        bus.cfg_offset = '0;
        bus.out_ready  = 1'b0;
        rst = 1'b1;
        tick(); tick();
        check("rst.valid", bus.out_valid, 0);
        check("rst.addr", bus.out_addr, 0);
        check("rst.last", bus.out_last, 0);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        rst = 1'b0;
        tick();

        e = {16'd1, 16'd2, 16'd3};
        d = {16'd0, 16'd10, 16'd1};
        build(e, d, 16'd100, total);
        check("model.2d_b3", exp_q[3], 112);
        check("model.2d_last", exp_q[5], 114);
        run(e, d, 16'd100, 0, 0, "scan2d");
        idle_check("scan2d");
        run(e, d, 16'd100, 1, 0, "stall2d");
        idle_check("stall2d");

        run({16'd2, 16'd2, 16'd2}, {16'd956, 16'd60, 16'd4}, 16'd0, 0, 0, "cube");
        idle_check("cube");
        run({16'd1, 16'd1, 16'd1}, {16'd7, 16'd8, 16'd9}, 16'h1234, 0, 0, "single");
        idle_check("single");
        run({16'd1, 16'd5, 16'd0}, {16'd1, 16'd1, 16'd1}, 16'h0042, 0, 0, "zero");
        idle_check("zero");
        run({16'd1, 16'd1, 16'd2}, {16'd0, 16'd0, 16'd1}, 16'hFFFF, 2, 1, "wrap");
        idle_check("wrap");

        // Back-to-back: second start lands on the done cycle of the first.
        run(e, d, 16'd100, 0, 0, "b2b_a");
        run({16'd2, 16'd2, 16'd2}, {16'd956, 16'd60, 16'd4}, 16'd0, 0, 0, "b2b_b");
        idle_check("b2b");

        // Abandon a run with reset after three accepted beats.
        bus.cfg_extent = e;
        bus.cfg_delta  = d;
        bus.cfg_offset = 16'd100;
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        check("abort.pre_addr", bus.out_addr, 16'd112);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.valid", bus.out_valid, 0);
        check("abort.addr", bus.out_addr, 0);
        check("abort.last", bus.out_last, 0);
        check("abort.busy", bus.busy, 0);
        check("abort.done", bus.done, 0);
        tick();
        check("abort.done2", bus.done, 0);
        run(e, d, 16'd100, 0, 0, "replay");
        idle_check("replay");

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < DIMS; k++) begin
                e[k*16 +: 16] = 16'($urandom_range(1, 3));
                d[k*16 +: 16] = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) e[$urandom_range(0, DIMS-1)*16 +: 16] = 16'd0;
            run(e, d, 16'($urandom), 2, 1'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 1) == 1) idle_check("rand");
        end
        idle_check("final");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/affine_addr_gen_nd.md
Name: affine_addr_gen_nd

Overview:
- Parametrised N-dimensional affine address generator; successor to the fixed 2-D scan chain (inner counter, stride-select accumulator, offset adder).
- Each `start` runs one complete nested loop. It emits one address per accepted beat over a valid/ready stream, flags the final beat, and pulses `done`.
- Feeds memory/line-buffer read ports in the op datapath. Configuration is latched per run, so the host may change inputs mid-run.

Parameters:
- DIMS, 3, number of loop dimensions (1..8); dimension 0 is innermost.
- WIDTH, 16, bit width of extents, deltas, offset, counters and address.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; accepted only in IDLE.
- cfg_extent  in  DIMS*WIDTH  per-dim trip count, dim d at bits [d*WIDTH +: WIDTH].
- cfg_delta  in  DIMS*WIDTH  per-dim address delta, same packing.
- cfg_offset  in  WIDTH  base address added to the accumulator.
- out_valid  out  1  out_addr holds a valid beat.
- out_ready  in  1  consumer accepts beat.
- out_addr  out  WIDTH  generated address.
- out_last  out  1  high with the final beat of the run.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the run completes.

Behaviour:
- States: IDLE, RUN. Reset forces IDLE and clears all state.
- Reset values: out_valid=0, out_addr=0, out_last=0, busy=0, done=0; idx[*]=0; acc=0.
- IDLE & start at cycle t:
  - Latch extent, delta and offset.
  - Clear idx[*] and acc.
  - If any extent is 0: stay IDLE and assert done=1 at t+1. No beat is emitted.
  - Otherwise: enter RUN. At t+1, out_valid=1 and out_addr=offset.
- out_addr is always acc+offset (mod 2^WIDTH), taken from registered state, so it is stable while stalled.
- out_last=1 when every idx[d]==extent[d]-1 and out_valid=1.
- Advance occurs only on out_valid & out_ready:
  - k = lowest d with idx[d] != extent[d]-1.
  - idx[k] += 1; idx[0..k-1] cleared to 0; higher dims unchanged.
  - acc += delta[k] (mod 2^WIDTH).
  - delta[k] is the full address step for that carry, including rewind of the inner dims. This matches the 2-D x_stride/y_stride convention.
- Handshake on a beat with out_last=1:
  - Next cycle: IDLE, out_valid=0, busy=0, done=1 for exactly one cycle.
  - The accumulator is not updated.
- Stall: while out_valid=1 & out_ready=0, out_addr, out_last and state hold. out_valid never drops before its handshake.
- start while RUN is ignored. start in the same cycle done=1 (IDLE) is accepted, giving back-to-back runs with one idle cycle between beats.
- Extent 1 in a dimension: that index is always at max, so carries pass through it.
- Total beats per run = product of extents. No overflow check is made on counters or address; arithmetic wraps.
- rst asserted mid-RUN: next cycle IDLE with reset values, no done pulse, partial run abandoned.
- Throughput: one beat per cycle with out_ready held high. No combinational path from out_ready to out_valid or out_addr.

Test Plan:
- DIMS=2, extent=(3,2), delta=(1,10), offset=100, ready=1 → addrs 100,101,102,112,113,114 on consecutive cycles. out_last only on 114. done one cycle later, busy low after.
- Same config with ready toggled 1,0,0,1,… → identical address sequence. out_addr/out_last stable during stalls. Beat count 6.
- DIMS=3, extent=(2,2,2), delta=(4,-4+64,-68+1024) mod 2^16 (i.e. 4, 60, 956), offset=0 → 0,4,64,68,1024,1028,1088,1092. last on 1092.
- extent=(1,1) offset=0x1234 → single beat 0x1234 with out_last=1. Then extent=(0,5) → no out_valid, done at t+1.
- offset=0xFFFF, extent=(2,1), delta=(1,0) → 0xFFFF, 0x0000 (wrap). Start pulse during RUN is ignored with no sequence disturbance.
- rst asserted after 3rd beat → next cycle all outputs 0, no done. A fresh start replays the sequence from the beginning.
